// File: rtl/addsub_pkg.sv
// Shared opcode encodings, flag bit positions and flag packing for the add/sub pipeline.
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int FLG_C     = 0;
   localparam int FLG_V     = 1;
   localparam int FLG_Z     = 2;
   localparam int FLG_N     = 3;
   localparam int NUM_FLAGS = 4;

   typedef logic [NUM_FLAGS-1:0] flags_t;

   function automatic flags_t pack_flags(input logic c, input logic v,
                                         input logic z, input logic n);
      flags_t f;
      f        = '0;
      f[FLG_C] = c;
      f[FLG_V] = v;
      f[FLG_Z] = z;
      f[FLG_N] = n;
      return f;
   endfunction

endpackage

// File: rtl/addsub_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, occupancy counter drives full/empty.
module addsub_cmd_fifo #(
   parameter  int DATA_W = 9,
   parameter  int DEPTH  = 4,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [CNT_W-1:0]  o_count
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic w_full;
   logic w_empty;
   logic w_push_en;
   logic w_pop_en;

   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign w_empty   = (r_count == '0);
   // A push while full is dropped even if a pop frees a slot this cycle.
   assign w_push_en = i_push && !w_full;
   assign w_pop_en  = i_pop && !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop_en) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push_en, w_pop_en})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset: contents are meaningless while the count says empty.
   always_ff @(posedge clk) begin
      if (w_push_en) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/addsub_op_pipeline.sv
// Buffered add/subtract stage: command FIFO feeding a registered result with C/V/Z/N flags.
module addsub_op_pipeline
   import addsub_pkg::*;
#(
   parameter  int WIDTH      = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg,
   output logic [CNT_W-1:0] fifo_count
);

   localparam int ENTRY_W = 2 * WIDTH + 1;

   logic [ENTRY_W-1:0] w_entry_in;
   logic [ENTRY_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_issue;
   logic [CNT_W-1:0]   w_count;

   logic [WIDTH-1:0]   w_head_a;
   logic [WIDTH-1:0]   w_head_b;
   logic               w_head_sub;
   logic [WIDTH-1:0]   w_bx;
   logic [WIDTH:0]     w_sum;
   logic               w_ovf;
   flags_t             w_flags;

   logic               r_out_valid;
   logic [WIDTH-1:0]   r_out_result;
   flags_t             r_flags;

   assign w_entry_in = {in_sub, in_a, in_b};
   assign in_ready   = !w_full;
   assign w_push     = in_valid && !w_full;
   assign w_issue    = !w_empty && (!r_out_valid || out_ready);

   addsub_cmd_fifo #(
      .DATA_W (ENTRY_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_issue),
      .i_data  (w_entry_in),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_head_sub = (w_head[ENTRY_W-1] == OP_SUB);
   assign w_head_a   = w_head[2*WIDTH-1:WIDTH];
   assign w_head_b   = w_head[WIDTH-1:0];

   // Subtraction as A + ~B + 1; carry out therefore means "no borrow".
   assign w_bx  = w_head_b ^ {WIDTH{w_head_sub}};
   assign w_sum = {1'b0, w_head_a} + {1'b0, w_bx} + (WIDTH+1)'(w_head_sub);
   assign w_ovf = (w_head_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != w_head_a[WIDTH-1]);

   always_comb begin
      w_flags = '0;
      w_flags = pack_flags(w_sum[WIDTH], w_ovf, (w_sum[WIDTH-1:0] == '0), w_sum[WIDTH-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_flags      <= '0;
      end else if (w_issue) begin
         r_out_valid  <= 1'b1;
         r_out_result <= w_sum[WIDTH-1:0];
         r_flags      <= w_flags;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_cout   = r_flags[FLG_C];
   assign out_ovf    = r_flags[FLG_V];
   assign out_zero   = r_flags[FLG_Z];
   assign out_neg    = r_flags[FLG_N];
   assign fifo_count = w_count;

endmodule

// File: tb/tb_addsub_op_pipeline.sv
// Bench for addsub_op_pipeline: directed arithmetic cases, backpressure, reset, random streaming.
module tb_addsub_op_pipeline;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         out_cout;
   logic         out_ovf;
   logic         out_zero;
   logic         out_neg;
   logic [2:0]   fifo_count;

   typedef struct packed {
      logic [3:0] res;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   addsub_op_pipeline #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sub     (in_sub),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_ovf    (out_ovf),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, unsigned for result/carry, signed for overflow.
   function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic sub);
      exp_t e;
      int   ua, ub, sa, sb, r, sr;
      ua = int'(a);
      ub = int'(b);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      if (!sub) begin
         r   = ua + ub;
         sr  = sa + sb;
         e.c = (r > 15);
      end else begin
         r   = ua - ub;
         sr  = sa - sb;
         e.c = (ua >= ub);
      end
      e.res = r[3:0];
      e.v   = (sr > 7) || (sr < -8);
      e.z   = (e.res == 4'd0);
      e.n   = e.res[3];
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.res = out_result;
      o.c   = out_cout;
      o.v   = out_ovf;
      o.z   = out_zero;
      o.n   = out_neg;
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // One clock of streaming: sample handshakes on the falling edge, score, then step past the rising edge.
   task automatic cycle(output bit pushed, output bit popped);
      @(negedge clk);
      pushed = in_valid && in_ready;
      popped = out_valid && out_ready;
      if (out_valid) begin
         if (exp_q.size() == 0) check("unexpected_result", 32'(observed()), 32'hFFFF_FFFF);
         else                   check("stream_data", 32'(observed()), 32'(exp_q[0]));
      end
      if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
      if (pushed) exp_q.push_back(model(in_a, in_b, in_sub));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bit pu, po;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) cycle(pu, po);
      check("drain_all_results", 32'(exp_q.size()), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);
      check("drain_fifo_count", 32'(fifo_count), 32'd0);
   endtask

   // Single command through an idle pipeline, with latency and drop-off checks.
   task automatic single_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic sub, input exp_t e);
      in_a      = a;
      in_b      = b;
      in_sub    = sub;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check({tag, "_lat_valid0"}, 32'(out_valid), 32'd0);
      check({tag, "_lat_count1"}, 32'(fifo_count), 32'd1);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_data"}, 32'(observed()), 32'(e));
      check({tag, "_count0"}, 32'(fifo_count), 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_drop"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         pu, po;
      logic [3:0] ra, rb;
      logic       rs;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_fifo_count", 32'(fifo_count), 32'd0);
      check("rst_result_flags", 32'(observed()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      single_op("add_3p4",   4'h3, 4'h4, 1'b0, 8'b0111_0000);
      single_op("add_ovf",   4'h7, 4'h1, 1'b0, 8'b1000_0101);
      single_op("add_wrap",  4'hF, 4'h1, 1'b0, 8'b0000_1010);
      single_op("sub_5m5",   4'h5, 4'h5, 1'b1, 8'b0000_1010);
      single_op("sub_2m3",   4'h2, 4'h3, 1'b1, 8'b1111_0001);
      single_op("sub_ovf",   4'h8, 4'h1, 1'b1, 8'b0111_1100);

      for (int i = 0; i < 12; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         rs = 1'($urandom);
         single_op("rand_single", ra, rb, rs, model(ra, rb, rs));
      end

      // Backpressure: five commands with the consumer stalled.
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_a     = 4'($urandom);
         in_b     = 4'($urandom);
         in_sub   = 1'($urandom);
         cycle(pu, po);
         check("bp_push", 32'(pu), 32'd1);
      end
      in_a   = 4'($urandom);
      in_b   = 4'($urandom);
      in_sub = 1'($urandom);
      check("bp_fifo_count", 32'(fifo_count), 32'd4);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < 2; k++) begin
         cycle(pu, po);
         check("bp_hold_no_push", 32'(pu), 32'd0);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      // Release with the sixth command still offered: it must wait for a free slot.
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle(pu, po);
         check("bp_consecutive", 32'(po), 32'd1);
         if (k == 0) check("full_pop_no_push", 32'(pu), 32'd0);
         if (pu) in_valid = 1'b0;
      end
      drain();

      // Reset with commands queued and a result held.
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_a     = 4'($urandom);
         in_b     = 4'($urandom);
         in_sub   = 1'($urandom);
         cycle(pu, po);
      end
      in_valid = 1'b0;
      check("pre_rst_count", 32'(fifo_count), 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_result", 32'(observed()), 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      single_op("post_rst_1p1", 4'h1, 4'h1, 1'b0, 8'b0010_0000);

      // Random streaming with random stalls on both sides.
      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         in_a      = 4'($urandom);
         in_b      = 4'($urandom);
         in_sub    = 1'($urandom);
         out_ready = ($urandom_range(0, 99) < 60);
         cycle(pu, po);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
